// File: rtl/pt2262_tx_scheduler.sv
// pt2262_tx_scheduler: round-robin share of one PT2262 encoder, REPEAT watchdog-supervised frames per granted word
module pt2262_tx_scheduler #(
  parameter int NREQ    = 4,
  parameter int REPEAT  = 4,
  parameter int TIMEOUT = 250000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] addr_i,
  input  logic [4*NREQ-1:0] data_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   ack_o,
  output logic              err_o,
  output logic [7:0]        enc_A,
  output logic [3:0]        enc_D,
  output logic              enc_start,
  input  logic              enc_frame_done,
  output logic              busy_o
);
  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  typedef enum logic [2:0] {IDLE, GRANT, START, WAIT_FRAME, DONE, FAIL} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] owner_q, owner_d, rr_q, rr_d, off, pick, rr_next;
  logic [PW:0] sum;
  logic [2*NREQ-1:0] req_rot;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic [WW-1:0] wd_q, wd_d;
  logic serving_d;
  assign cnt_inc = cnt_q + 4'd1;
  assign rr_next = owner_q == PW'(NREQ - 1) ? '0 : owner_q + 1'b1;
  assign sum = {1'b0, rr_q} + {1'b0, off};
  assign pick = PW'(sum >= (PW+1)'(NREQ) ? sum - (PW+1)'(NREQ) : sum);
  assign serving_d = state_d == GRANT || state_d == START || state_d == WAIT_FRAME;
  // rotate requests so bit 0 is rr_q, then take the smallest offset that is requesting
  always_comb begin
    req_rot = {req_i, req_i} >> rr_q;
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (req_rot[i]) off = PW'(i);
  end
  // sequencer: arbitration, frame loop, watchdog and completion
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d = rr_q;
    cnt_d = cnt_q;
    wd_d = wd_q;
    case (state_q)
      IDLE: if (|req_i) begin
        state_d = GRANT;
        owner_d = pick;
      end
      GRANT: begin
        cnt_d = '0;
        state_d = START;
      end
      START: begin
        wd_d = '0;
        state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        wd_d = wd_q == '1 ? wd_q : wd_q + 1'b1;
        if (enc_frame_done) begin
          cnt_d = cnt_inc;
          state_d = !req_i[owner_q] ? FAIL : cnt_inc == 4'(REPEAT) ? DONE : START;
        end else if (wd_q == WW'(TIMEOUT - 2)) state_d = FAIL;
      end
      DONE, FAIL: begin
        rr_d = rr_next;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state plus all outputs are flops fed from the next state, so outputs carry no decode glitches
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      wd_q <= '0;
      gnt_o <= '0;
      ack_o <= '0;
      err_o <= 1'b0;
      enc_start <= 1'b0;
      busy_o <= 1'b0;
      enc_A <= '0;
      enc_D <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      wd_q <= wd_d;
      gnt_o <= serving_d ? ONE << owner_d : '0;
      ack_o <= state_d == DONE ? ONE << owner_q : '0;
      err_o <= state_d == FAIL;
      enc_start <= state_d == START;
      busy_o <= state_d != IDLE;
      if (state_d == GRANT) begin
        enc_A <= addr_i[{owner_d, 3'b000} +: 8];
        enc_D <= data_i[{owner_d, 2'b00} +: 4];
      end
    end
  end
endmodule

// File: tb/tb_pt2262_tx_scheduler.sv
// tb_pt2262_tx_scheduler: randomized scenarios checked against an arithmetic round-robin/timing model
module tb_pt2262_tx_scheduler;
  localparam int NREQ = 4, REPEAT = 4, TIMEOUT = 1000;
  logic clk = 0, reset = 0, enc_frame_done = 0;
  logic [NREQ-1:0] req_i = '0;
  logic [8*NREQ-1:0] addr_i = '0;
  logic [4*NREQ-1:0] data_i = '0;
  logic [NREQ-1:0] gnt_o, ack_o;
  logic err_o, enc_start, busy_o;
  logic [7:0] enc_A;
  logic [3:0] enc_D;
  int vectors = 0, miscompares = 0, cyc = 0, cd = 0, d_cur = 100, m_rr = 0;
  int o_own, o_tg, o_ts, o_te, o_starts, o_acks, o_errs;
  logic [NREQ-1:0] o_gnt, o_ackv, o_gnt_end;
  logic [7:0] o_a;
  logic [3:0] o_d;
  bit o_ad_ok, o_hung;

  pt2262_tx_scheduler #(.NREQ(NREQ), .REPEAT(REPEAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .addr_i(addr_i), .data_i(data_i),
    .gnt_o(gnt_o), .ack_o(ack_o), .err_o(err_o), .enc_A(enc_A), .enc_D(enc_D),
    .enc_start(enc_start), .enc_frame_done(enc_frame_done), .busy_o(busy_o));

  always #5 clk = ~clk;

  // advance one cycle; encoder model answers each enc_start after d_cur cycles (0 = never)
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    enc_frame_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) enc_frame_done = 1'b1;
    end
    if (enc_start && d_cur > 0) cd = d_cur;
  endtask

  function automatic int rr_pick(input int rr, input logic [NREQ-1:0] r);
    int p;
    p = -1;
    for (int i = NREQ - 1; i >= 0; i--) if (r[(rr + i) % NREQ]) p = (rr + i) % NREQ;
    return p;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] slice_a(input int i);
    logic [8*NREQ-1:0] s;
    s = addr_i >> (8 * i);
    return s[7:0];
  endfunction

  function automatic logic [3:0] slice_d(input int i);
    logic [4*NREQ-1:0] s;
    s = data_i >> (4 * i);
    return s[3:0];
  endfunction

  // drive one transaction to completion and record what the DUT did; requester drops on ack/err
  task automatic serve(input int mid_n, input logic [NREQ-1:0] mid_req);
    o_own = -1; o_gnt = '0; o_tg = -1; o_ts = -1; o_te = -1; o_starts = 0; o_acks = 0;
    o_errs = 0; o_ackv = '0; o_gnt_end = '1; o_ad_ok = 1; o_hung = 0; cd = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (gnt_o != '0) begin
        o_gnt = gnt_o;
        o_tg = cyc;
        break;
      end
    end
    if (o_tg < 0) begin
      o_hung = 1;
      return;
    end
    for (int i = 0; i < NREQ; i++) if (o_gnt[i]) o_own = i;
    for (int i = 0; i < 20 * TIMEOUT && busy_o; i++) begin
      step();
      if (enc_start) begin
        o_starts++;
        if (o_starts == 1) begin
          o_a = enc_A; o_d = enc_D; o_ts = cyc;
        end else if (enc_A !== o_a || enc_D !== o_d) o_ad_ok = 0;
        if (o_starts == mid_n) req_i = mid_req;
        addr_i = (8*NREQ)'($urandom);
        data_i = (4*NREQ)'($urandom);
      end
      if (ack_o != '0) begin
        o_acks++; o_ackv = ack_o; o_te = cyc; o_gnt_end = gnt_o;
      end
      if (err_o) begin
        o_errs++; o_te = cyc; o_gnt_end = gnt_o;
      end
      if (ack_o != '0 || err_o) req_i[o_own] = 1'b0;
    end
    if (busy_o) o_hung = 1;
  endtask

  task automatic test_reset();
    reset = 0; req_i = NREQ'($urandom); addr_i = (8*NREQ)'($urandom); data_i = (4*NREQ)'($urandom);
    repeat (3) step();
    vectors++; if (gnt_o !== '0) begin miscompares++; $display("FAIL reset_gnt got %b want 0", gnt_o); end
    vectors++; if (ack_o !== '0) begin miscompares++; $display("FAIL reset_ack got %b want 0", ack_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_o); end
    vectors++; if (enc_start !== 1'b0) begin miscompares++; $display("FAIL reset_start got %b want 0", enc_start); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_o); end
    vectors++; if ({enc_A, enc_D} !== 12'h0) begin miscompares++; $display("FAIL reset_enc got %h/%h want 0/0", enc_A, enc_D); end
    reset = 1; req_i = '0; m_rr = 0;
    step();
  endtask

  task automatic test_single();
    int t0, d;
    d = 100; d_cur = d;
    addr_i = (8*NREQ)'($urandom); data_i = (4*NREQ)'($urandom);
    addr_i[7:0] = 8'hA5; data_i[3:0] = 4'h9;
    req_i = 4'b0001; t0 = cyc;
    serve(0, '0);
    vectors++; if (o_hung) begin miscompares++; $display("FAIL single_hang got busy/no grant want completion"); end
    vectors++; if (o_tg !== t0 + 1) begin miscompares++; $display("FAIL single_gnt_time got %0d want %0d", o_tg, t0 + 1); end
    vectors++; if (o_gnt !== 4'b0001) begin miscompares++; $display("FAIL single_gnt got %b want 0001", o_gnt); end
    vectors++; if (o_ts !== o_tg + 1) begin miscompares++; $display("FAIL single_start_time got %0d want %0d", o_ts, o_tg + 1); end
    vectors++; if (o_starts !== REPEAT) begin miscompares++; $display("FAIL single_starts got %0d want %0d", o_starts, REPEAT); end
    vectors++; if (o_a !== 8'hA5 || o_d !== 4'h9 || !o_ad_ok) begin miscompares++; $display("FAIL single_enc got %h/%h stable=%0d want a5/9", o_a, o_d, o_ad_ok); end
    vectors++; if (o_acks !== 1 || o_ackv !== 4'b0001 || o_errs !== 0) begin miscompares++; $display("FAIL single_ack got %0d x %b err %0d want 1 x 0001 err 0", o_acks, o_ackv, o_errs); end
    vectors++; if (o_te !== o_tg + 1 + REPEAT * (d + 1)) begin miscompares++; $display("FAIL single_done_time got %0d want %0d", o_te, o_tg + 1 + REPEAT * (d + 1)); end
    vectors++; if (o_gnt_end !== '0 || busy_o !== 1'b0) begin miscompares++; $display("FAIL single_release got gnt %b busy %b want 0 0", o_gnt_end, busy_o); end
    m_rr = 1; req_i = '0;
    step();
  endtask

  task automatic test_random_words();
    for (int k = 0; k < 6; k++) begin
      int exp_own, d;
      logic [7:0] ea;
      logic [3:0] ed;
      d = $urandom_range(1, 150); d_cur = d;
      addr_i = (8*NREQ)'($urandom); data_i = (4*NREQ)'($urandom);
      req_i = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      exp_own = rr_pick(m_rr, req_i);
      ea = slice_a(exp_own); ed = slice_d(exp_own);
      serve(0, '0);
      vectors++; if (o_hung || o_own !== exp_own) begin miscompares++; $display("FAIL rand_owner got %0d hung=%0d want %0d", o_own, o_hung, exp_own); end
      vectors++; if (o_a !== ea || o_d !== ed || !o_ad_ok) begin miscompares++; $display("FAIL rand_enc got %h/%h stable=%0d want %h/%h", o_a, o_d, o_ad_ok, ea, ed); end
      vectors++; if (o_starts !== REPEAT || o_acks !== 1 || o_ackv !== onehot(exp_own) || o_errs !== 0) begin miscompares++; $display("FAIL rand_frames got starts %0d ack %b err %0d want %0d %b 0", o_starts, o_ackv, o_errs, REPEAT, onehot(exp_own)); end
      vectors++; if (o_te !== o_tg + 1 + REPEAT * (d + 1)) begin miscompares++; $display("FAIL rand_done_time got %0d want %0d", o_te, o_tg + 1 + REPEAT * (d + 1)); end
      m_rr = (exp_own + 1) % NREQ; req_i = '0;
      step();
    end
  endtask

  task automatic test_round_robin();
    int exp_own, prev_te;
    int order[7];
    reset = 0; step(); reset = 1; m_rr = 0; cd = 0;
    d_cur = $urandom_range(1, 20); req_i = '1; prev_te = -1;
    for (int k = 0; k < 7; k++) begin
      exp_own = rr_pick(m_rr, req_i);
      serve(k == 4 ? 1 : 0, 4'b0101);
      order[k] = o_own;
      vectors++; if (o_hung || o_own !== exp_own || o_acks !== 1) begin miscompares++; $display("FAIL rr_grant%0d got %0d acks %0d want %0d", k, o_own, o_acks, exp_own); end
      if (prev_te >= 0) begin
        vectors++; if (o_tg - prev_te !== 2) begin miscompares++; $display("FAIL rr_gap%0d got %0d want 2", k, o_tg - prev_te); end
      end
      prev_te = o_te; m_rr = (exp_own + 1) % NREQ;
      req_i[exp_own] = 1'b1;
    end
    vectors++; if (order[4] !== 0 || order[5] !== 2 || order[6] !== 0) begin miscompares++; $display("FAIL rr_inject got %0d,%0d,%0d want 0,2,0", order[4], order[5], order[6]); end
    req_i = '0;
    repeat (2) step();
  endtask

  task automatic test_timeout();
    int j;
    for (int k = 0; k < 2; k++) begin
      d_cur = k == 0 ? 0 : TIMEOUT;
      j = $urandom_range(0, NREQ - 1);
      req_i = onehot(j);
      serve(0, '0);
      vectors++; if (o_hung || o_own !== j || o_starts !== 1) begin miscompares++; $display("FAIL to_frames%0d got owner %0d starts %0d want %0d 1", k, o_own, o_starts, j); end
      vectors++; if (o_errs !== 1 || o_acks !== 0 || o_gnt_end !== '0) begin miscompares++; $display("FAIL to_err%0d got err %0d ack %0d gnt %b want 1 0 0", k, o_errs, o_acks, o_gnt_end); end
      vectors++; if (o_te !== o_ts + TIMEOUT) begin miscompares++; $display("FAIL to_time%0d got %0d want %0d", k, o_te - o_ts, TIMEOUT); end
      m_rr = (j + 1) % NREQ; req_i = '0;
      step();
    end
    d_cur = 5; req_i = '1;
    serve(0, '0);
    vectors++; if (o_hung || o_own !== m_rr) begin miscompares++; $display("FAIL to_rr_advance got %0d want %0d", o_own, m_rr); end
    m_rr = (m_rr + 1) % NREQ; req_i = '0;
    step();
  endtask

  task automatic test_simultaneous();
    int exp_own;
    d_cur = TIMEOUT - 1;
    req_i = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    exp_own = rr_pick(m_rr, req_i);
    serve(0, '0);
    vectors++; if (o_hung || o_acks !== 1 || o_ackv !== onehot(exp_own) || o_errs !== 0) begin miscompares++; $display("FAIL sim_ack got ack %b err %0d want %b 0", o_ackv, o_errs, onehot(exp_own)); end
    vectors++; if (o_te !== o_tg + 1 + REPEAT * TIMEOUT) begin miscompares++; $display("FAIL sim_time got %0d want %0d", o_te, o_tg + 1 + REPEAT * TIMEOUT); end
    m_rr = (exp_own + 1) % NREQ; req_i = '0;
    step();
  endtask

  task automatic test_withdraw();
    int d;
    d = $urandom_range(10, 80); d_cur = d;
    req_i = 4'b0010;
    serve(2, '0);
    vectors++; if (o_hung || o_own !== 1 || o_starts !== 2) begin miscompares++; $display("FAIL wd_frames got owner %0d starts %0d want 1 2", o_own, o_starts); end
    vectors++; if (o_errs !== 1 || o_acks !== 0) begin miscompares++; $display("FAIL wd_err got err %0d ack %0d want 1 0", o_errs, o_acks); end
    vectors++; if (o_te !== o_tg + 1 + 2 * (d + 1)) begin miscompares++; $display("FAIL wd_time got %0d want %0d", o_te, o_tg + 1 + 2 * (d + 1)); end
    m_rr = 2; req_i = '0;
    step();
  endtask

  task automatic test_reset_mid();
    int n, t_rel;
    d_cur = 50; req_i = 4'b0100; n = 0;
    for (int i = 0; i < 2000 && n < 3; i++) begin
      step();
      if (enc_start) n++;
    end
    repeat (10) step();
    reset = 0;
    step();
    vectors++; if (n !== 3 || {gnt_o, ack_o, err_o, enc_start, busy_o} !== '0) begin miscompares++; $display("FAIL rmid_ctrl got starts %0d gnt %b ack %b err %b start %b busy %b want 3 and all 0", n, gnt_o, ack_o, err_o, enc_start, busy_o); end
    vectors++; if ({enc_A, enc_D} !== 12'h0) begin miscompares++; $display("FAIL rmid_enc got %h/%h want 0/0", enc_A, enc_D); end
    reset = 1; req_i = 4'b0010; cd = 0; d_cur = 20; t_rel = cyc; m_rr = 0;
    serve(0, '0);
    vectors++; if (o_hung || o_gnt !== 4'b0010 || o_tg !== t_rel + 1) begin miscompares++; $display("FAIL rmid_regrant got %b at %0d want 0010 at %0d", o_gnt, o_tg, t_rel + 1); end
    vectors++; if (o_acks !== 1 || o_errs !== 0) begin miscompares++; $display("FAIL rmid_ack got ack %0d err %0d want 1 0", o_acks, o_errs); end
    req_i = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_random_words();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_withdraw();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
